// File: rtl/sha3_padder.sv
// -----------------------------------------------------------------------------
// sha3_padder
//
// Packs a byte-oriented message (arriving as 32-bit words, earliest byte in
// in[31:24]) into RATE_WORDS-word rate blocks for the SHA-3 permutation. The
// final block gets multi-rate padding: the domain byte right after the last
// message byte, zero fill, and 0x80 OR'd into the last byte of the block.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   in           message word, in[31:24] is the earliest byte
//   in_ready     in / is_last / byte_num valid this cycle
//   is_last      this word ends the message
//   byte_num     valid bytes (0..3, MSB-aligned) in the last word
//   buffer_full  padder cannot take a word this cycle
//   out          assembled block, word 0 in the top 32 bits
//   out_ready    out holds a complete block
//   f_ack        permutation stage has consumed out
// -----------------------------------------------------------------------------
module sha3_padder #(
    parameter logic [7:0] DOMAIN_BYTE = 8'h06,
    parameter int         RATE_WORDS  = 18
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               in,
    input  logic                      in_ready,
    input  logic                      is_last,
    input  logic [1:0]                byte_num,
    output logic                      buffer_full,
    output logic [32*RATE_WORDS-1:0]  out,
    output logic                      out_ready,
    input  logic                      f_ack
);

    localparam int            CW       = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {ABSORB, PAD, FULL, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            final_reg, final_next;

    logic            write_en;
    logic [31:0]     write_word;
    logic            clear;
    logic [31:0]     last_word;
    logic [31:0]     pad_tail;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ABSORB;
            count_reg <= '0;
            final_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            final_reg <= final_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ABSORB: begin
                // A word landing on the last index closes the block directly;
                // a short final word still needs zero fill via PAD.
                if (in_ready) begin
                    if (count_reg == LAST_IDX)
                        state_next = FULL;
                    else if (is_last)
                        state_next = PAD;
                end
            end
            PAD: begin
                if (count_reg == LAST_IDX)
                    state_next = FULL;
            end
            FULL: begin
                if (f_ack)
                    state_next = final_reg ? DONE : ABSORB;
            end
            default: begin
                // DONE is terminal until reset
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: depends on state only, never on in_ready
    // -------------------------------------------------------------------------
    always_comb begin
        buffer_full = (state_reg != ABSORB);
        out_ready   = (state_reg == FULL);
    end

    // -------------------------------------------------------------------------
    // Final-word formation: keep the valid leading bytes, append the domain
    // byte, drop whatever junk sits below it.
    // -------------------------------------------------------------------------
    always_comb begin
        case (byte_num)
            2'd0:    last_word = {DOMAIN_BYTE, 24'h0};
            2'd1:    last_word = {in[31:24], DOMAIN_BYTE, 16'h0};
            2'd2:    last_word = {in[31:16], DOMAIN_BYTE, 8'h0};
            default: last_word = {in[31:8], DOMAIN_BYTE};
        endcase
    end

    // The closing 0x80 belongs to whichever final-block word lands last.
    assign pad_tail = (count_reg == LAST_IDX) ? 32'h0000_0080 : 32'h0;

    // -------------------------------------------------------------------------
    // Datapath control: what gets written at the current index this cycle
    // -------------------------------------------------------------------------
    always_comb begin
        write_en   = 1'b0;
        write_word = '0;
        clear      = 1'b0;
        count_next = count_reg;
        final_next = final_reg;
        case (state_reg)
            ABSORB: begin
                if (in_ready) begin
                    write_en   = 1'b1;
                    count_next = count_reg + CW'(1);
                    if (is_last) begin
                        final_next = 1'b1;
                        write_word = last_word | pad_tail;
                    end else begin
                        write_word = in;
                    end
                end
            end
            PAD: begin
                write_en   = 1'b1;
                write_word = pad_tail;
                count_next = count_reg + CW'(1);
            end
            FULL: begin
                if (f_ack) begin
                    clear      = 1'b1;
                    count_next = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Block storage: one register per rate word, selected by the word index
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < RATE_WORDS; gi++) begin : g_word
        logic [31:0] word_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                word_reg <= '0;
            else if (clear)
                word_reg <= '0;
            else if (write_en && (count_reg == CW'(gi)))
                word_reg <= write_word;
        end

        assign out[32*(RATE_WORDS-gi)-1 -: 32] = word_reg;
    end

endmodule

// File: tb/tb_sha3_padder.sv
// -----------------------------------------------------------------------------
// tb_sha3_padder
//
// Self-checking bench for sha3_padder: table of single-word messages, hand
// sequences for the multi-cycle corners (full-block final word, exact-block
// message, held output, async reset mid-pad) and randomized messages with
// random handshake timing compared against a byte-level padding model.
// -----------------------------------------------------------------------------
module tb_sha3_padder;

    localparam logic [7:0] DOM = 8'h06;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in;
    logic         in_ready;
    logic         is_last;
    logic [1:0]   byte_num;
    logic         buffer_full;
    logic [575:0] out;
    logic         out_ready;
    logic         f_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha3_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .f_ack       (f_ack)
    );

    // Reference data built from the message bytes
    logic [7:0]   msg[$];
    logic [31:0]  wdata[$];
    logic         wlast[$];
    logic [1:0]   wn[$];
    logic [575:0] exp_q[$];

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in       = '0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = 2'd0;
        f_ack    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Present a word until the DUT takes it (bounded).
    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] n);
        int  tries;
        logic bf;
        in       = d;
        is_last  = l;
        byte_num = n;
        in_ready = 1'b1;
        tries    = 0;
        do begin
            bf = buffer_full;
            step();
            tries++;
        end while (bf && tries < 200);
        if (bf) begin
            checks++;
            failures++;
            $display("FAIL send_word accepted=0 required=1");
        end
        in_ready = 1'b0;
        is_last  = 1'b0;
    endtask

    // Cycles counted from the accept edge: 1 means out_ready in the very next cycle.
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!out_ready && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic ack();
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
    endtask

    // Split msg into input words (junk in the unused low bytes of the last
    // word) and compute the expected padded blocks at byte level.
    task automatic build_model();
        logic [7:0]   p[$];
        logic [575:0] blk;
        logic [31:0]  d;
        int nfull, rem;
        wdata.delete();
        wlast.delete();
        wn.delete();
        exp_q.delete();
        nfull = msg.size() / 4;
        rem   = msg.size() % 4;
        for (int w = 0; w < nfull; w++) begin
            wdata.push_back({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]});
            wlast.push_back(1'b0);
            wn.push_back(2'd0);
        end
        d = $urandom;
        for (int b = 0; b < rem; b++)
            d[31-8*b -: 8] = msg[4*nfull+b];
        wdata.push_back(d);
        wlast.push_back(1'b1);
        wn.push_back(2'(rem));
        p = msg;
        p.push_back(DOM);
        while (p.size() % 72 != 0)
            p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        for (int b = 0; b < p.size() / 72; b++) begin
            blk = '0;
            for (int j = 0; j < 72; j++)
                blk = {blk[567:0], p[72*b+j]};
            exp_q.push_back(blk);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  n;
        logic [31:0] w0;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int           lat;
        logic [575:0] exp;
        logic [575:0] empty_blk;
        int           lens[5];
        int           wi, bi, cyc;
        logic         seen, bf, ordy;

        reset = 1'b1;
        idle();

        empty_blk = '0;
        empty_blk[575:568] = 8'h06;
        empty_blk[7:0]     = 8'h80;

        vecs[0] = '{data: 32'h6162_6300, n: 2'd3, w0: 32'h6162_6306};
        vecs[1] = '{data: 32'hDEAD_BEEF, n: 2'd0, w0: 32'h0600_0000};
        vecs[2] = '{data: 32'hAB12_3456, n: 2'd1, w0: 32'hAB06_0000};
        vecs[3] = '{data: 32'hCAFE_F00D, n: 2'd2, w0: 32'hCAFE_0600};
        vecs[4] = '{data: 32'hFFFF_FFFF, n: 2'd3, w0: 32'hFFFF_FF06};

        // ---------------- reset state ----------------
        #2;
        check("reset out", out, '0);
        check("reset out_ready", 576'(out_ready), 576'd0);
        check("reset buffer_full", 576'(buffer_full), 576'd0);
        do_reset();
        check("post-reset buffer_full", 576'(buffer_full), 576'd0);

        // ---------------- single-word messages (table) ----------------
        for (int i = 0; i < 5; i++) begin
            do_reset();
            send_word(vecs[i].data, 1'b1, vecs[i].n);
            // Upstream keeps pushing during PAD/FULL: nothing may be stored.
            in       = 32'hFFFF_FFFF;
            is_last  = 1'b1;
            byte_num = 2'd3;
            in_ready = 1'b1;
            wait_ready(lat);
            check($sformatf("vec%0d latency", i), 576'(lat), 576'd18);
            exp = '0;
            exp[575:544] = vecs[i].w0;
            exp[7:0]     = 8'h80;
            check($sformatf("vec%0d block", i), out, exp);
            ack();
            check($sformatf("vec%0d done out_ready", i), 576'(out_ready), 576'd0);
            check($sformatf("vec%0d done out", i), out, '0);
            step();
            step();
            check($sformatf("vec%0d done buffer_full", i), 576'(buffer_full), 576'd1);
            idle();
        end

        // ---------------- 17 full words + final word on index 17 ----------------
        do_reset();
        msg.delete();
        for (int i = 0; i < 68; i++) msg.push_back(8'hA5);
        msg.push_back(8'h11);
        msg.push_back(8'h22);
        msg.push_back(8'h33);
        build_model();
        for (int w = 0; w < wdata.size(); w++) send_word(wdata[w], wlast[w], wn[w]);
        wait_ready(lat);
        check("last@17 latency", 576'(lat), 576'd1);
        check("last@17 tail", 576'(out[31:0]), 576'(32'h1122_3386));
        check("last@17 block", out, exp_q[0]);
        ack();
        check("last@17 done buffer_full", 576'(buffer_full), 576'd1);

        // ---------------- 18 non-last words, held output ----------------
        do_reset();
        exp = '0;
        for (int w = 1; w <= 18; w++) begin
            send_word(32'(w), 1'b0, 2'd0);
            exp = {exp[543:0], 32'(w)};
        end
        wait_ready(lat);
        check("full18 latency", 576'(lat), 576'd1);
        check("full18 block", out, exp);
        in       = 32'h5555_AAAA;
        in_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("full18 held out", out, exp);
        check("full18 held out_ready", 576'(out_ready), 576'd1);
        check("full18 held buffer_full", 576'(buffer_full), 576'd1);
        in_ready = 1'b0;
        ack();
        check("full18 ack out_ready", 576'(out_ready), 576'd0);
        check("full18 ack buffer_full", 576'(buffer_full), 576'd0);
        check("full18 ack out", out, '0);
        // Stray acknowledge while nothing is pending
        ack();
        check("stray ack out_ready", 576'(out_ready), 576'd0);
        check("stray ack buffer_full", 576'(buffer_full), 576'd0);
        // is_last without in_ready must do nothing
        is_last = 1'b1;
        step();
        step();
        is_last = 1'b0;
        check("is_last no in_ready", 576'(buffer_full), 576'd0);
        send_word(32'h0, 1'b1, 2'd0);
        wait_ready(lat);
        check("second block latency", 576'(lat), 576'd18);
        check("second block", out, empty_blk);
        ack();
        check("second block done", 576'(buffer_full), 576'd1);

        // ---------------- async reset mid-PAD ----------------
        do_reset();
        send_word(32'h0, 1'b1, 2'd0);
        for (int c = 0; c < 5; c++) step();
        #3;
        reset = 1'b1;
        #1;
        check("async rst out", out, '0);
        check("async rst out_ready", 576'(out_ready), 576'd0);
        check("async rst buffer_full", 576'(buffer_full), 576'd0);
        #1;
        reset = 1'b0;
        step();
        send_word(32'h0, 1'b1, 2'd0);
        wait_ready(lat);
        check("after rst latency", 576'(lat), 576'd18);
        check("after rst block", out, empty_blk);
        ack();

        // ---------------- randomized messages ----------------
        lens[0] = 0;
        lens[1] = 68;
        lens[2] = 71;
        lens[3] = 72;
        lens[4] = 144;
        for (int m = 0; m < 14; m++) begin
            do_reset();
            msg.delete();
            for (int i = 0; i < ((m < 5) ? lens[m] : $urandom_range(0, 200)); i++)
                msg.push_back(8'($urandom));
            build_model();
            wi   = 0;
            bi   = 0;
            cyc  = 0;
            seen = 1'b0;
            while (bi < exp_q.size() && cyc < 4000) begin
                if (wi < wdata.size() && $urandom_range(0, 3) != 0) begin
                    in       = wdata[wi];
                    is_last  = wlast[wi];
                    byte_num = wn[wi];
                    in_ready = 1'b1;
                end else begin
                    in       = $urandom;
                    is_last  = 1'($urandom_range(0, 1));
                    byte_num = 2'($urandom_range(0, 3));
                    in_ready = 1'b0;
                end
                f_ack = out_ready ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
                bf    = buffer_full;
                ordy  = out_ready;
                if (ordy && !seen) begin
                    check($sformatf("rand m%0d len%0d blk%0d", m, msg.size(), bi), out, exp_q[bi]);
                    seen = 1'b1;
                end
                step();
                cyc++;
                if (in_ready && !bf) wi++;
                if (ordy && f_ack) begin
                    bi++;
                    seen = 1'b0;
                end
            end
            idle();
            check($sformatf("rand m%0d blocks", m), 576'(bi), 576'(exp_q.size()));
            check($sformatf("rand m%0d words", m), 576'(wi), 576'(wdata.size()));
            step();
            check($sformatf("rand m%0d done", m), 576'({buffer_full, out_ready}), 576'(2'b10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
